// File: rtl/wc_pkg.sv
// Shared constants and state encoding for the Winograd tile-stream adapter.
package wc_pkg;

   localparam int WC_DW   = 10;
   localparam int WC_TILE = 8;
   localparam int WC_NOUT = 5;
   localparam int WC_FILT = 4;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      PAD   = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } wc_ts_state_t;

endpackage

// File: rtl/wc_win_shift.sv
// TILE x DW sample window. Newest sample enters at the low end; the oldest
// falls off the top. Clear combined with shift restarts the window with a
// single sample.
module wc_win_shift
   import wc_pkg::*;
#(
   parameter int TILE = WC_TILE,
   parameter int DW   = WC_DW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_clr,
   input  logic                 i_shift,
   input  logic                 i_zero,
   input  logic [DW-1:0]        i_data,
   output logic [TILE*DW-1:0]   o_win
);

   logic [TILE*DW-1:0] r_win;
   logic [TILE*DW-1:0] w_base;
   logic [DW-1:0]      w_in;

   // select what the shift starts from and what enters at the bottom
   always_comb begin
      w_base = i_clr  ? '0 : r_win;
      w_in   = i_zero ? {DW{1'b0}} : i_data;
   end

   // window register: shift, clear, or hold
   always_ff @(posedge clk) begin
      if (!rst)
         r_win <= '0;
      else if (i_shift)
         r_win <= {w_base[TILE*DW-DW-1:0], w_in};
      else if (i_clr)
         r_win <= '0;
   end

   assign o_win = r_win;

endmodule

// File: rtl/wc_tile_stream.sv
// Stream adapter feeding the 8-in/5-out Winograd core: builds overlapping
// tiles (stride 5) on D, holds them for WC_LAT cycles, captures Z and
// serializes the five results with valid/ready.
// Optional feature macro: WC_TILE_STREAM_PAD_EN (zero-pad a short row tail
// flagged by s_last; without it s_last is ignored).
module wc_tile_stream
   import wc_pkg::*;
#(
   parameter int DW     = WC_DW,
   parameter int TILE   = WC_TILE,
   parameter int NOUT   = WC_NOUT,
   parameter int WC_LAT = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DW-1:0]        s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic                 s_first,
   input  logic                 s_last,
   output logic [TILE*DW-1:0]   D,
   input  logic [NOUT*DW-1:0]   Z,
   output logic [DW-1:0]        m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last
);

   localparam int CW = $clog2(TILE + 1);
   localparam int LW = (WC_LAT > 1) ? $clog2(WC_LAT) : 1;
   localparam int KW = (NOUT > 1) ? $clog2(NOUT) : 1;

   wc_ts_state_t        r_state, w_nxt;
   logic [CW-1:0]       r_cnt;        // samples taken since the tile started
   logic                r_need8;      // 1: full 8-sample fill, 0: 5-sample stride fill
   logic [LW-1:0]       r_lat;
   logic [KW-1:0]       r_k;
   logic [NOUT*DW-1:0]  r_hold;

   logic                w_acc;
   logic [CW-1:0]       w_need, w_need_eff, w_cnt_nxt;
   logic                w_shift, w_zero, w_clr;

`ifdef WC_TILE_STREAM_PAD_EN
   logic                r_pad_nxt;    // row ended in this tile: next tile starts fresh
`else
   logic                w_unused_last;
   assign w_unused_last = s_last;
`endif

   // handshake qualifiers and fill targets
   always_comb begin
      s_ready    = (r_state == FILL) & rst;
      w_acc      = s_valid & s_ready;
      w_need     = r_need8 ? CW'(TILE) : CW'(NOUT);
      w_need_eff = s_first ? CW'(TILE) : w_need;
      w_cnt_nxt  = s_first ? CW'(1) : r_cnt + CW'(1);
   end

   // next-state and window control
   always_comb begin
      w_nxt   = r_state;
      w_shift = 1'b0;
      w_zero  = 1'b0;
      w_clr   = 1'b0;
      case (r_state)
         FILL: if (w_acc) begin
            w_shift = 1'b1;
            w_clr   = s_first;
            if (w_cnt_nxt == w_need_eff)
               w_nxt = WAIT;
`ifdef WC_TILE_STREAM_PAD_EN
            else if (s_last)
               w_nxt = PAD;
`endif
         end
`ifdef WC_TILE_STREAM_PAD_EN
         PAD: begin
            w_shift = 1'b1;
            w_zero  = 1'b1;
            if (r_cnt + CW'(1) == w_need)
               w_nxt = WAIT;
         end
`endif
         WAIT:    if (r_lat == LW'(WC_LAT - 1)) w_nxt = DRAIN;
         DRAIN:   if (m_ready && r_k == KW'(NOUT - 1)) w_nxt = FILL;
         default: w_nxt = FILL;
      endcase
   end

   // state, counters and result hold register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= FILL;
         r_cnt   <= '0;
         r_need8 <= 1'b1;
         r_lat   <= '0;
         r_k     <= '0;
         r_hold  <= '0;
`ifdef WC_TILE_STREAM_PAD_EN
         r_pad_nxt <= 1'b0;
`endif
      end else begin
         r_state <= w_nxt;
         case (r_state)
            FILL: if (w_acc) begin
               r_cnt <= w_cnt_nxt;
               if (s_first) r_need8 <= 1'b1;
`ifdef WC_TILE_STREAM_PAD_EN
               if (s_last) r_pad_nxt <= 1'b1;
`endif
            end
`ifdef WC_TILE_STREAM_PAD_EN
            PAD: r_cnt <= r_cnt + CW'(1);
`endif
            WAIT: begin
               if (r_lat == LW'(WC_LAT - 1)) begin
                  r_lat  <= '0;
                  r_hold <= Z;
               end else begin
                  r_lat <= r_lat + LW'(1);
               end
            end
            DRAIN: if (m_ready) begin
               if (r_k == KW'(NOUT - 1)) begin
                  // last 3 samples stay in the window as overlap unless the row ended
                  r_k   <= '0;
                  r_cnt <= '0;
`ifdef WC_TILE_STREAM_PAD_EN
                  r_need8   <= r_pad_nxt;
                  r_pad_nxt <= 1'b0;
`else
                  r_need8 <= 1'b0;
`endif
               end else begin
                  r_k <= r_k + KW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // output 0 lives in the top field of Z
   always_comb begin
      m_valid = (r_state == DRAIN);
      m_last  = m_valid && (r_k == KW'(NOUT - 1));
      m_data  = r_hold[(NOUT - 1 - int'(r_k)) * DW +: DW];
   end

   wc_win_shift #(.TILE(TILE), .DW(DW)) u_win (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_clr),
      .i_shift (w_shift),
      .i_zero  (w_zero),
      .i_data  (s_data),
      .o_win   (D)
   );

endmodule

// File: tb/tb_wc_tile_stream.sv
// Bench for wc_tile_stream with a stand-in WC core (simple 3-tap arithmetic
// delayed through a pipeline so Z is only correct once D has been stable
// long enough). A queue model of the sample window supplies expected tiles.
module tb_wc_tile_stream;

   localparam int LAT = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  s_data;
   logic        s_valid, s_ready, s_first, s_last;
   logic [79:0] D;
   logic [49:0] Z;
   logic [9:0]  m_data;
   logic        m_valid, m_ready, m_last;

   int n_checks = 0;
   int n_pass   = 0;

   int mw[$];
   int mcnt, mneed;
   bit mpad;
   int dq[$];

   always #5 clk = ~clk;

   wc_tile_stream #(.WC_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .s_first(s_first), .s_last(s_last), .D(D), .Z(Z),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
   );

   function automatic int sx(input int v);
      int t;
      t = v & 1023;
      return (t >= 512) ? t - 1024 : t;
   endfunction

   // stand-in core: out k = s[k] + 2*s[k+1] - s[k+3], wrapped to 10 bits
   function automatic logic [49:0] stub_z(input logic [79:0] d);
      logic [49:0] z;
      int s[8];
      int a;
      z = '0;
      for (int i = 0; i < 8; i++) begin
         logic [9:0] f;
         f = d[79 - 10*i -: 10];
         s[i] = sx(int'(f));
      end
      for (int k = 0; k < 5; k++) begin
         a = s[k] + 2*s[k+1] - s[k+3];
         z[49 - 10*k -: 10] = a[9:0];
      end
      return z;
   endfunction

   logic [49:0] zp [0:LAT-2];
   always @(posedge clk) begin
      zp[0] <= stub_z(D);
      for (int i = 1; i < LAT-1; i++) zp[i] <= zp[i-1];
   end
   assign Z = zp[LAT-2];

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_checks++;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      mw = {};
      repeat (8) mw.push_back(0);
      mcnt = 0; mneed = 8; mpad = 0;
   endtask

   task automatic model_push(input int d, input bit first, input bit last,
                             output bit done, output int npad);
      npad = 0;
      if (first) begin mcnt = 1; mneed = 8; end
      else mcnt++;
      mw.push_back(d); void'(mw.pop_front());
`ifdef WC_TILE_STREAM_PAD_EN
      if (last) begin
         mpad = 1;
         while (mcnt < mneed) begin
            mw.push_back(0); void'(mw.pop_front());
            mcnt++; npad++;
         end
      end
`else
      if (last) npad = 0;
`endif
      done = (mcnt == mneed);
   endtask

   task automatic model_drain_end();
      mcnt = 0;
      mneed = mpad ? 8 : 5;
      mpad = 0;
   endtask

   function automatic logic [79:0] model_tile();
      logic [79:0] r;
      int v;
      for (int i = 0; i < 8; i++) begin
         v = mw[i];
         r[79 - 10*i -: 10] = v[9:0];
      end
      return r;
   endfunction

   function automatic logic [9:0] model_out(input int k);
      int a;
      a = sx(mw[k]) + 2*sx(mw[k+1]) - sx(mw[k+3]);
      return a[9:0];
   endfunction

   task automatic push(input logic [9:0] d, input bit first, input bit last);
      int g;
      s_data = d; s_valid = 1'b1; s_first = first; s_last = last;
      g = 0;
      while (!s_ready && g < 50) begin @(posedge clk); #1; g++; end
      if (g >= 50) chk("s_ready_timeout", 80'(s_ready), 80'd1);
      @(posedge clk); #1;
      s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
   endtask

   // feed one tile, check latency/D, then drain with m_ready asserted rdy_pct% of cycles;
   // abort_at >= 0 returns while output abort_at is presented (before its handshake)
   task automatic run_tile(input int first_at, input int last_at, input int rdy_pct, input int abort_at);
      int n, npad, np, cyc, stalls;
      bit done, rdy;
      logic [9:0] d;
      n = 0; npad = 0; done = 0;
      while (!done) begin
         n++;
         if (dq.size() > 0) d = 10'(dq.pop_front());
         else d = 10'($urandom_range(0, 1023));
         push(d, n == first_at, n == last_at);
         model_push(int'(d), n == first_at, n == last_at, done, np);
         npad += np;
      end
      cyc = 0;
      while (!m_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
      chk("valid_latency", 80'(cyc), 80'(npad + LAT));
      chk("tile_D", D, model_tile());
      for (int k = 0; k < 5; k++) begin
         stalls = 0;
         forever begin
            chk("m_valid", 80'(m_valid), 80'd1);
            chk("m_data", 80'(m_data), 80'(model_out(k)));
            chk("m_last", 80'(m_last), 80'(k == 4));
            chk("s_ready_drain", 80'(s_ready), 80'd0);
            if (k == abort_at) return;
            rdy = ($urandom_range(0, 99) < rdy_pct) || (stalls >= 20);
            m_ready = rdy;
            @(posedge clk); #1;
            m_ready = 1'b0;
            if (rdy) break;
            stalls++;
         end
      end
      chk("post_drain_valid", 80'(m_valid), 80'd0);
      chk("post_drain_ready", 80'(s_ready), 80'd1);
      model_drain_end();
   endtask

   initial begin
      rst = 1'b0; s_data = '0; s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0; m_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", 80'(s_ready), 80'd0);
      chk("rst_m_valid", 80'(m_valid), 80'd0);
      chk("rst_m_last",  80'(m_last),  80'd0);
      chk("rst_m_data",  80'(m_data),  80'd0);
      chk("rst_D",       D,            80'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rel_s_ready", 80'(s_ready), 80'd1);

      // directed first tile
      dq = {2, 1014, 3, 4, 1011, 1006, 1008, 996};
      run_tile(1, 0, 100, -1);
      chk("tile1_D_literal", D,
          80'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000_1111100100);

      // stride tile: overlap of -18, -16, -28 on top
      run_tile(0, 0, 100, -1);
      chk("overlap_D", 80'(D[79:50]), 80'({10'd1006, 10'd1008, 10'd996}));

      // random data with backpressure
      for (int t = 0; t < 4; t++) run_tile(0, 0, 50, -1);

      // s_first on the 4th sample of a stride fill
      run_tile(4, 0, 70, -1);
      run_tile(0, 0, 50, -1);

      // s_last on 2nd new sample of a stride fill
      run_tile(0, 2, 100, -1);
`ifdef WC_TILE_STREAM_PAD_EN
      chk("pad_zero_D", 80'(D[29:0]), 80'd0);
`endif
      run_tile(0, 0, 60, -1);
      run_tile(0, 0, 60, -1);

      // reset while the 3rd output is presented
      run_tile(0, 0, 100, 2);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_m_valid", 80'(m_valid), 80'd0);
      chk("abort_D",       D,            80'd0);
      chk("abort_s_ready", 80'(s_ready), 80'd0);
      chk("abort_m_data",  80'(m_data),  80'd0);
      rst = 1'b1;
      model_reset();
      @(posedge clk); #1;
      run_tile(0, 0, 100, -1);
      run_tile(0, 0, 50, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
